// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: drives all four {a,b} vectors into a 2-input gate and checks gate_out against a truth table.
// Optional fail_mask output: define GATE_SEQ_FAIL_MASK_EN.
module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             loop,
  input  logic [3:0]       truth_table,
  input  logic             gate_out,
  output logic             a,
  output logic             b,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
`ifdef GATE_SEQ_FAIL_MASK_EN
  ,
  output logic [3:0]       fail_mask
`endif
);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  localparam int SCW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SC_LOAD = SCW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic a_q, a_d, b_q, b_d, pass_q, pass_d, miss;
  logic [1:0] vec_q, vec_d;
  logic [3:0] tbl_q, tbl_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SCW-1:0] cnt_q, cnt_d;
`ifdef GATE_SEQ_FAIL_MASK_EN
  logic [3:0] mask_q, mask_d;
  assign fail_mask = mask_q;
`endif
  assign miss = gate_out != tbl_q[vec_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      vec_q   <= 2'd0;
      tbl_q   <= 4'd0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef GATE_SEQ_FAIL_MASK_EN
      mask_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
`ifdef GATE_SEQ_FAIL_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
`ifdef GATE_SEQ_FAIL_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        tbl_d   = truth_table;
        err_d   = '0;
        vec_d   = 2'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
`ifdef GATE_SEQ_FAIL_MASK_EN
        mask_d  = 4'd0;
`endif
      end
      APPLY: begin
        cnt_d   = SC_LOAD;
        state_d = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        err_d = (miss && err_q != '1) ? err_q + 1'b1 : err_q;
`ifdef GATE_SEQ_FAIL_MASK_EN
        mask_d = mask_q | ({3'd0, miss} << vec_q);
`endif
        // pass is registered with the last sample so it is valid alongside the done pulse
        if (vec_q == 2'd3) begin
          state_d = DONE;
          pass_d  = err_d == '0;
        end else begin
          state_d    = APPLY;
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
        end
      end
      DONE: begin
        state_d = loop ? APPLY : IDLE;
        vec_d   = 2'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign a         = a_q;
  assign b         = b_q;
  assign vec_idx   = vec_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign pass      = pass_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb_gate_vector_sequencer: scoreboard bench driving a behavioural NOR gate through the sequencer.
module tb_gate_vector_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, loop = 1'b0, stuck = 1'b0;
  logic [3:0] truth_table = 4'd0;
  logic a, b, busy, done, pass, gate_out;
  logic [1:0] vec_idx;
  logic [2:0] err_count;
`ifdef GATE_SEQ_FAIL_MASK_EN
  logic [3:0] fail_mask;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0, c0;
  typedef struct {int err; bit pass; logic [3:0] mask; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign gate_out = stuck ? 1'b0 : ~(a | b);

  gate_vector_sequencer #(.SETTLE_CYCLES(2), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .truth_table(truth_table),
    .gate_out(gate_out), .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count)
`ifdef GATE_SEQ_FAIL_MASK_EN
    , .fail_mask(fail_mask)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic go(input logic [3:0] tbl, input bit lp, output int c);
    start = 1'b1;
    truth_table = tbl;
    loop = lp;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) if (rst_n && done) begin
    if (q.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      e = q.pop_front();
      chk("done_cycle", cyc, e.cyc);
      chk("err_count", int'(err_count), e.err);
      chk("pass", int'(pass), int'(e.pass));
`ifdef GATE_SEQ_FAIL_MASK_EN
      chk("fail_mask", int'(fail_mask), int'(e.mask));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_vec", vec_idx, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_pass", pass, 0); chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // NOR table with a good NOR: check the vector order and hold through settle
    go(4'b0001, 1'b0, c0);
    q.push_back('{0, 1'b1, 4'b0000, c0 + 17});
    for (int i = 0; i < 4; i++) begin
      wait_cyc(c0 + 1 + 4 * i);
      chk("apply_ab", {a, b}, i); chk("apply_vec", vec_idx, i); chk("apply_busy", busy, 1);
      wait_cyc(c0 + 3 + 4 * i);
      chk("settle_ab", {a, b}, i);
    end
    wait_cyc(c0 + 18);
    chk("idle_busy", busy, 0); chk("idle_ab", {a, b}, 0);
    // stuck-at-0 output
    stuck = 1'b1;
    go(4'b0001, 1'b0, c0);
    q.push_back('{1, 1'b0, 4'b0001, c0 + 17});
    wait_cyc(c0 + 18);
    stuck = 1'b0;
    // AND table against NOR gate
    go(4'b1000, 1'b0, c0);
    q.push_back('{2, 1'b0, 4'b1001, c0 + 17});
    wait_cyc(c0 + 18);
    // start re-pulsed and table changed mid-run are ignored
    go(4'b0001, 1'b0, c0);
    q.push_back('{0, 1'b1, 4'b0000, c0 + 17});
    wait_cyc(c0 + 6);
    start = 1'b1;
    truth_table = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c0 + 18);
    chk("ignore_busy", busy, 0);
    // loop mode with saturating 3-bit counter
    go(4'b1000, 1'b1, c0);
    q.push_back('{2, 1'b0, 4'b1001, c0 + 17});
    q.push_back('{4, 1'b0, 4'b1001, c0 + 34});
    q.push_back('{6, 1'b0, 4'b1001, c0 + 51});
    q.push_back('{7, 1'b0, 4'b1001, c0 + 68});
    q.push_back('{7, 1'b0, 4'b1001, c0 + 85});
    wait_cyc(c0 + 70);
    loop = 1'b0;
    wait_cyc(c0 + 86);
    chk("loop_end_busy", busy, 0); chk("loop_end_ab", {a, b}, 0);
    // async reset in the middle of vector 2 settle
    go(4'b1000, 1'b0, c0);
    wait_cyc(c0 + 10);
    chk("pre_rst_err", err_count, 1); chk("pre_rst_ab", {a, b}, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_a", a, 0); chk("arst_b", b, 0); chk("arst_busy", busy, 0);
    chk("arst_err", err_count, 0); chk("arst_vec", vec_idx, 0);
`ifdef GATE_SEQ_FAIL_MASK_EN
    chk("arst_mask", fail_mask, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(4'b0001, 1'b0, c0);
    q.push_back('{0, 1'b1, 4'b0000, c0 + 17});
    wait_cyc(c0 + 18);
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Sequencer for a 2-input logic gate under test, such as the team's nor_gate. On start it drives all four input combinations {a,b} = 00, 01, 10, 11 in order. After a programmable settle time it samples the gate output for each vector and compares it against a 4-bit expected truth table. It counts mismatches and reports pass/fail, replacing the hand-written #delay stimulus used in gate benches with a clocked, self-checking controller.

Parameters:
SETTLE_CYCLES, 2, cycles between applying a vector and sampling gate_out; 0 is legal and skips the SETTLE state.
CNT_W, 4, width of err_count; must be >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begins a run when sampled high in IDLE; ignored in all other states.
loop  input  1  sampled in DONE; if high, the next pass starts automatically without clearing err_count.
truth_table  input  4  expected output; bit i is the expected gate_out for vector i = {a,b}, e.g. NOR = 4'b0001.
gate_out  input  1  output of the gate under test.
a  output  1  gate input A, registered.
b  output  1  gate input B, registered.
vec_idx  output  2  index of the vector currently applied.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at the end of each pass.
pass  output  1  high when err_count==0; updated in DONE and held until the next start.
err_count  output  CNT_W  cumulative mismatch count; saturates at 2^CNT_W-1.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - a, b, vec_idx, busy, done, pass, err_count all go to 0.
  - The latched table clears to 0.
  - Any run in progress is abandoned; no done pulse is issued.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - a=b=0, busy=0.
  - start=1 latches truth_table into an internal register, clears err_count, sets vec_idx=0, and moves to APPLY.
- APPLY (1 cycle):
  - a=vec_idx[1], b=vec_idx[0], registered so valid from this cycle.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE (SETTLE_CYCLES cycles):
  - a and b are held.
  - A down-counter loaded in APPLY; exits to SAMPLE when it expires.
- SAMPLE (1 cycle):
  - Compares gate_out with the latched table bit [vec_idx].
  - On mismatch, err_count increments unless it is already at its maximum (saturating).
  - If vec_idx==3, go to DONE; otherwise vec_idx increments and the next state is APPLY.
- DONE (1 cycle):
  - done=1.
  - pass is updated from err_count, including any increment from the final SAMPLE.
  - If loop=1: vec_idx=0, go to APPLY; the latched table and err_count are kept.
  - If loop=0: go to IDLE, with a=b=0 from the IDLE cycle onward.
- Timing: start sampled at edge k → APPLY in cycle k+1 → done high in cycle k+1+4*(SETTLE_CYCLES+2). With the default setting, done is high in cycle k+17.
- truth_table changes after the latch point are ignored until the next start from IDLE.
- start is ignored while busy, including start=1 in the DONE cycle.
- gate_out is assumed stable by the SAMPLE cycle; the block adds no synchronizer.

Optional Feature:
GATE_SEQ_FAIL_MASK_EN
- Defined:
  - Adds output fail_mask[3:0]; bit i is set when vector i mismatches in SAMPLE.
  - In loop mode, bits accumulate across passes (OR).
  - Cleared on reset and on start from IDLE.
- Undefined:
  - The port and its logic are absent; all other behaviour is identical.

Test Plan:
1. truth_table=4'b0001, gate_out driven by a behavioural NOR of a,b, start pulse at edge k → {a,b} sequence 00,01,10,11; done at k+17; pass=1; err_count=0; fail_mask=0000.
2. Same table, gate_out stuck at 0 → err_count=1, pass=0, fail_mask=0001.
3. truth_table=4'b1000 (AND) with NOR model → err_count=2, pass=0, fail_mask=1001.
4. Start re-pulsed during SETTLE of vector 1, and truth_table changed to 4'b1111 mid-run, with NOR model → run unaffected; done at original cycle; pass=1.
5. CNT_W=3, loop=1, AND table with NOR model (2 errors/pass) → err_count 2, 4, 6, 7, 7 after successive done pulses; loop=0 after pass 5 → IDLE, busy=0.
6. rst_n pulsed low in SETTLE of vector 2 → a=b=0, busy=0, err_count=0 immediately (asynchronously); no done pulse; a later start performs a clean full run.
